// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port unified memory: data (MEM) beats fetch (IF),
// one access in flight at a time. Optional fetch starvation guard: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halted,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            state_q, state_d;
  logic              owner_dm_q, owner_dm_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              if_gnt_q, if_gnt_d, dm_gnt_q, dm_gnt_d;
  logic              if_valid_q, if_valid_d, dm_valid_q, dm_valid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic              if_elig, force_if, pick_if;

  assign if_elig = if_req & ~halted;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;

  assign force_if = (starve_q == 3'(STARVE_MAX));

  // Counts arbitrations fetch lost in a row; only meaningful while fetch stays eligible.
  always_comb begin
    starve_d = starve_q;
    if (state_q == S_IDLE) begin
      if (!if_elig || pick_if)
        starve_d = '0;
      else if (dm_req && starve_q != 3'd7)
        starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign force_if = 1'b0;
`endif

  assign pick_if = if_elig & (~dm_req | force_if);

  always_comb begin
    state_d    = state_q;
    owner_dm_d = owner_dm_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_gnt_d   = 1'b0;
    dm_gnt_d   = 1'b0;
    if_valid_d = 1'b0;
    dm_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dm_req || if_elig) begin
          state_d = S_ACCESS;
          if (pick_if) begin
            owner_dm_d = 1'b0;
            m_we_d     = 1'b0;
            m_addr_d   = if_addr;
            if_gnt_d   = 1'b1;
          end else begin
            owner_dm_d = 1'b1;
            m_we_d     = dm_we;
            m_addr_d   = dm_addr;
            m_wdata_d  = dm_wdata;
            dm_gnt_d   = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (m_ready) begin
          state_d = S_IDLE;
          if (owner_dm_q) begin
            dm_valid_d = 1'b1;
            if (!m_we_q) dm_rdata_d = m_rdata;
          end else begin
            if_valid_d = 1'b1;
            if_rdata_d = m_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_dm_q <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_gnt_q   <= 1'b0;
      dm_gnt_q   <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_dm_q <= owner_dm_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_gnt_q   <= if_gnt_d;
      dm_gnt_q   <= dm_gnt_d;
      if_valid_q <= if_valid_d;
      dm_valid_q <= dm_valid_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign m_en     = (state_q == S_ACCESS);
  assign m_we     = m_en & m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_gnt   = if_gnt_q;
  assign dm_gnt   = dm_gnt_q;
  assign if_valid = if_valid_q;
  assign dm_valid = dm_valid_q;
  assign if_rdata = if_rdata_q;
  assign dm_rdata = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory and programmable wait states.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst, halted;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt, dm_valid;
  logic [DATA_W-1:0] dm_rdata;
  logic              m_en, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic              m_ready;

  logic [DATA_W-1:0] mem [0:1023];
  int unsigned       wait_cfg;
  int unsigned       wait_cnt;
  int                checks = 0;
  int                errors = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst), .halted(halted),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Memory acknowledges after wait_cfg stall cycles of a held m_en.
  assign m_ready = m_en && (wait_cnt >= wait_cfg);
  assign m_rdata = mem[m_addr];

  always @(posedge clk) begin
    if (m_en && !m_ready) wait_cnt <= wait_cnt + 1;
    else                  wait_cnt <= 0;
    if (m_en && m_we && m_ready) mem[m_addr] <= m_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({m_en, m_we, if_gnt, dm_gnt, if_valid, dm_valid} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000", {m_en, m_we, if_gnt, dm_gnt, if_valid, dm_valid});
    end
    checks++;
    if (m_addr !== '0 || m_wdata !== '0 || if_rdata !== '0 || dm_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data: addr %0h wdata %0h if_rdata %0h dm_rdata %0h want all 0",
               m_addr, m_wdata, if_rdata, dm_rdata);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_load();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd120;
    step();
    checks++;
    if (dm_gnt !== 1'b1 || m_en !== 1'b1 || m_addr !== 10'd120 || m_we !== 1'b0 || if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL load_gnt: gnt %b en %b addr %0d we %b want 1 1 120 0", dm_gnt, m_en, m_addr, m_we);
    end
    dm_req = 1'b0;
    step();
    checks++;
    if (dm_valid !== 1'b1 || dm_rdata !== 32'd85 || dm_gnt !== 1'b0) begin
      errors++;
      $display("FAIL load_valid: valid %b rdata %0d gnt %b want 1 85 0", dm_valid, dm_rdata, dm_gnt);
    end
    step();
    checks++;
    if (dm_valid !== 1'b0 || m_en !== 1'b0) begin
      errors++;
      $display("FAIL load_idle: valid %b en %b want 0 0", dm_valid, m_en);
    end
  endtask

  task automatic test_store_then_fetch();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'd121; dm_wdata = 32'd130;
    if_req = 1'b1; if_addr = 10'd0;
    step();
    checks++;
    if (dm_gnt !== 1'b1 || if_gnt !== 1'b0 || m_we !== 1'b1 || m_addr !== 10'd121 || m_wdata !== 32'd130) begin
      errors++;
      $display("FAIL store_gnt: dm_gnt %b if_gnt %b we %b addr %0d wdata %0d want 1 0 1 121 130",
               dm_gnt, if_gnt, m_we, m_addr, m_wdata);
    end
    dm_req = 1'b0; dm_we = 1'b0;
    step();
    checks++;
    if (dm_valid !== 1'b1 || dm_rdata !== 32'd85 || mem[121] !== 32'd130) begin
      errors++;
      $display("FAIL store_done: valid %b rdata %0d mem121 %0d want 1 85 130", dm_valid, dm_rdata, mem[121]);
    end
    step();
    checks++;
    if (if_gnt !== 1'b1 || m_en !== 1'b1 || m_addr !== 10'd0 || m_we !== 1'b0) begin
      errors++;
      $display("FAIL fetch_gnt: gnt %b en %b addr %0d we %b want 1 1 0 0", if_gnt, m_en, m_addr, m_we);
    end
    if_req = 1'b0;
    step();
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h28010078) begin
      errors++;
      $display("FAIL fetch_valid: valid %b rdata %h want 1 28010078", if_valid, if_rdata);
    end
    step();
  endtask

  task automatic test_wait_states();
    wait_cfg = 3;
    if_req = 1'b1; if_addr = 10'd5;
    step();
    if_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_en !== 1'b1 || m_addr !== 10'd5 || if_valid !== 1'b0 || if_gnt !== (i == 0)) begin
        errors++;
        $display("FAIL wait_hold[%0d]: en %b addr %0d valid %b gnt %b want 1 5 0 %b",
                 i, m_en, m_addr, if_valid, if_gnt, (i == 0));
      end
      step();
    end
    checks++;
    if (if_valid !== 1'b1 || if_rdata !== 32'hDEADBEEF || m_en !== 1'b0) begin
      errors++;
      $display("FAIL wait_valid: valid %b rdata %h en %b want 1 deadbeef 0", if_valid, if_rdata, m_en);
    end
    step();
    checks++;
    if (if_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_single: valid %b want 0", if_valid);
    end
    wait_cfg = 0;
  endtask

  task automatic test_halted();
    halted = 1'b1; if_req = 1'b1; if_addr = 10'd0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (if_gnt !== 1'b0 || m_en !== 1'b0) begin
        errors++;
        $display("FAIL halted_block[%0d]: gnt %b en %b want 0 0", i, if_gnt, m_en);
      end
    end
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd120;
    step();
    checks++;
    if (dm_gnt !== 1'b1 || if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL halted_dm_gnt: dm_gnt %b if_gnt %b want 1 0", dm_gnt, if_gnt);
    end
    dm_req = 1'b0;
    step();
    checks++;
    if (dm_valid !== 1'b1 || dm_rdata !== 32'd85) begin
      errors++;
      $display("FAIL halted_dm_valid: valid %b rdata %0d want 1 85", dm_valid, dm_rdata);
    end
    step();
    checks++;
    if (m_en !== 1'b0 || if_gnt !== 1'b0) begin
      errors++;
      $display("FAIL halted_after: en %b if_gnt %b want 0 0", m_en, if_gnt);
    end
    halted = 1'b0; if_req = 1'b0;
  endtask

  task automatic test_reset_in_access();
    wait_cfg = 5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd120;
    step();
    step();
    checks++;
    if (m_en !== 1'b1 || dm_gnt !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: en %b gnt %b want 1 0", m_en, dm_gnt);
    end
    rst = 1'b1;
    step();
    checks++;
    if (m_en !== 1'b0 || dm_valid !== 1'b0 || dm_gnt !== 1'b0 || dm_rdata !== '0) begin
      errors++;
      $display("FAIL rst_abort: en %b valid %b gnt %b rdata %0d want 0 0 0 0", m_en, dm_valid, dm_gnt, dm_rdata);
    end
    rst = 1'b0; wait_cfg = 0;
    step();
    checks++;
    if (dm_gnt !== 1'b1 || m_en !== 1'b1 || dm_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_regrant: gnt %b en %b valid %b want 1 1 0", dm_gnt, m_en, dm_valid);
    end
    dm_req = 1'b0;
    step();
    checks++;
    if (dm_valid !== 1'b1 || dm_rdata !== 32'd85) begin
      errors++;
      $display("FAIL rst_reload: valid %b rdata %0d want 1 85", dm_valid, dm_rdata);
    end
    step();
  endtask

  task automatic test_starvation();
    int d_since = 0;
    int f_total = 0;
    int d_total = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd120;
    if_req = 1'b1; if_addr = 10'd0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (dm_gnt === 1'b1) begin
        d_since++;
        d_total++;
      end
      if (if_gnt === 1'b1) begin
        f_total++;
        checks++;
        if (d_since !== 4) begin
          errors++;
          $display("FAIL starve_spacing: data grants before fetch %0d want 4", d_since);
        end
        d_since = 0;
      end
    end
    dm_req = 1'b0; if_req = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    checks++;
    if (f_total !== 2 || d_total !== 8) begin
      errors++;
      $display("FAIL starve_totals: fetch %0d data %0d want 2 8", f_total, d_total);
    end
`else
    checks++;
    if (f_total !== 0 || d_total !== 10) begin
      errors++;
      $display("FAIL starve_totals: fetch %0d data %0d want 0 10", f_total, d_total);
    end
`endif
    step();
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[0]   = 32'h28010078;
    mem[5]   = 32'hDEADBEEF;
    mem[120] = 32'd85;
    wait_cfg = 0;
    rst = 1'b1; halted = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

    test_reset();
    test_load();
    test_store_then_fetch();
    test_wait_states();
    test_halted();
    test_reset_in_access();
    test_starvation();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
